// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the adder stream controller
package adder_pkg;

    localparam int ADD_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } add_state_t;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] sum;
        logic                 carry;
    } add_result_t;

endpackage

// File: rtl/adder_stream_ctrl_result_fifo.sv
// rtl/adder_stream_ctrl_result_fifo.sv - show-ahead result queue for the adder stream controller
module result_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot the push may reuse, so a full queue still accepts a push in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adder_stream_ctrl.sv
// rtl/adder_stream_ctrl.sv - handshake front/back end around an external combinational adder
module adder_stream_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       input1,
    output logic [WIDTH-1:0]       input2,
    input  logic [WIDTH-1:0]       answer,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_carry,
    output logic [$clog2(DEPTH):0] count
);

    add_state_t     state;
    add_state_t     state_next;
    logic           load;
    logic           push;
    logic           pop;
    logic           carry;
    logic           fifo_full;
    logic           fifo_empty;
    logic [WIDTH:0] head;

    // A wrapped sum is always smaller than either operand, which gives the carry without a wider adder.
    assign carry = (answer < input1);

    assign in_ready  = (state == IDLE);
    assign load      = in_ready && in_valid;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_sum   = fifo_empty ? '0   : head[WIDTH:1];
    assign out_carry = fifo_empty ? 1'b0 : head[0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and FIFO write strobe; EXEC holds until the result has somewhere to go.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_next = EXEC;
            end
            EXEC: begin
                if (!fifo_full || pop) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand registers feeding the adder; held until the next accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input1 <= '0;
            input2 <= '0;
        end else if (load) begin
            input1 <= in_a;
            input2 <= in_b;
        end
    end

    result_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({answer, carry}),
        .pop       (pop),
        .head_data (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// tb/tb_adder_stream_ctrl.sv - scoreboard bench for adder_stream_ctrl
module tb_adder_stream_ctrl;
    import adder_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] answer;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;
    add_result_t exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the external N_bit_adder.
    assign answer = input1 + input2;

    adder_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .input1    (input1),
        .input2    (input2),
        .answer    (answer),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .count     (count)
    );

    // Inputs only change just after a rising edge, so the falling edge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got sum=%0h carry=%0b, required none", out_sum, out_carry);
                end else begin
                    add_result_t e;
                    e = exp_q.pop_front();
                    if (out_sum !== e.sum || out_carry !== e.carry) begin
                        errors++;
                        $display("FAIL result: got sum=%0h carry=%0b, required sum=%0h carry=%0b",
                                 out_sum, out_carry, e.sum, e.carry);
                    end
                end
            end
            if (in_valid && in_ready) begin
                logic [WIDTH:0] full_sum;
                add_result_t    e;
                full_sum = {1'b0, in_a} + {1'b0, in_b};
                e.sum    = full_sum[WIDTH-1:0];
                e.carry  = full_sum[WIDTH];
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !out_valid && in_ready) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== '0 ||
            input1 !== '0 || input2 !== '0 || out_sum !== '0 || out_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%0b out_valid=%0b count=%0d input1=%0h input2=%0h sum=%0h carry=%0b, required 1 0 0 0 0 0 0",
                     in_ready, out_valid, count, input1, input2, out_sum, out_carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(32'd1234, 32'd1111);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_edge: out_valid=%0b in_ready=%0b, required 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd2345 || out_carry !== 1'b0) begin
            errors++;
            $display("FAIL basic_two_edges: out_valid=%0b sum=%0d carry=%0b, required 1 2345 0",
                     out_valid, out_sum, out_carry);
        end
        wait_drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'd2);
        send(32'h8000_0000, 32'h8000_0000);
        send(32'hFFFF_FFFF, 32'd0);
        wait_drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(WIDTH'(i), WIDTH'(i + 1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'd1) begin
            errors++;
            $display("FAIL full_stall: count=%0d in_ready=%0b out_valid=%0b head=%0d, required 4 0 1 1",
                     count, in_ready, out_valid, out_sum);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b1 || out_sum !== 32'd3) begin
            errors++;
            $display("FAIL push_pop_full: count=%0d in_ready=%0b head=%0d, required 4 1 3", count, in_ready, out_sum);
        end
        wait_drain();
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL drained_count: count=%0d, required 0", count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'd10, 32'd20);
        send(32'd30, 32'd40);
        send(32'd50, 32'd60);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1 || input1 !== '0 || input2 !== '0) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%0b count=%0d in_ready=%0b input1=%0h input2=%0h, required 0 0 1 0 0",
                     out_valid, count, in_ready, input1, input2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'd7, 32'd8);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd15 || count !== 3'd1) begin
            errors++;
            $display("FAIL after_reset: out_valid=%0b sum=%0d count=%0d, required 1 15 1", out_valid, out_sum, count);
        end
        wait_drain();
    endtask

    task automatic test_soak();
        bit stop;
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [WIDTH-1:0] a;
                    logic [WIDTH-1:0] b;
                    a = $urandom();
                    b = $urandom();
                    if (i % 50 == 0) a = 32'hFFFF_FFFF;
                    send(a, b);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
